axis_fifo_arb: RTL
==================

AXIS_FIFO_ARB -- requirements
Module: axis_fifo_arb

Interface
REQ-001 Parameter NREQ, default 4: number of AXI-stream requesters sharing one FIFO write port, legal range 2..16.
REQ-002 Parameter DSIZE, default 32: data width per requester and FIFO write data width.
REQ-003 Parameter TIMEOUT, default 64: mid-packet idle-cycle limit, used only when ARB_TIMEOUT_EN is defined; legal range 2..65535.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s_tdata  in  NREQ*DSIZE  requester data; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-007 s_tvalid  in  NREQ  per-requester valid.
REQ-008 s_tlast  in  NREQ  per-requester end-of-packet.
REQ-009 s_tready  out  NREQ  per-requester ready.
REQ-010 fifo_wdata  out  DSIZE  data to the FIFO write port.
REQ-011 fifo_wlast  out  1  tlast of the current beat, for storage alongside the data.
REQ-012 fifo_winc  out  1  FIFO write strobe; high only when a beat is transferred.
REQ-013 fifo_wfull  in  1  FIFO full flag from the write domain.
REQ-014 grant  out  NREQ  one-hot owner of the write port; all zeros when idle.
REQ-015 timeout_err  out  1  one-cycle pulse on a forced grant release.

Function
REQ-016 The FSM SHALL have two states: IDLE and XFER.
REQ-017 In IDLE, grant, s_tready and fifo_winc SHALL be 0.
REQ-018 In IDLE with any s_tvalid high, the block SHALL choose the first valid requester scanning upward from rr_ptr+1 modulo NREQ, register grant, and enter XFER on the next edge.
REQ-019 Arbitration latency SHALL be exactly one cycle: the first beat can transfer in the cycle after the request is seen.
REQ-020 In XFER with grant index g, s_tready[g] SHALL equal ~fifo_wfull, and every other s_tready bit SHALL be 0.
REQ-021 In XFER, fifo_winc SHALL equal s_tvalid[g] & ~fifo_wfull, combinationally; fifo_wdata and fifo_wlast SHALL follow requester g.
REQ-022 A beat SHALL never be written while fifo_wfull is high; the grant SHALL be held through any full stall.
REQ-023 The grant SHALL be held until a transferred beat has s_tlast[g] high, i.e. packets are never interleaved.
REQ-024 On that last beat, the FSM SHALL return to IDLE, set rr_ptr to g, and clear grant on the next edge.
REQ-025 A new arbitration SHALL start only from IDLE, so there is one idle cycle between packets.
REQ-026 A single-beat packet (tvalid and tlast on the first beat) SHALL occupy one XFER cycle, or more if the FIFO is full.
REQ-027 Changes to s_tvalid of non-granted requesters during XFER SHALL have no effect.
REQ-028 The block SHALL neither reorder nor drop accepted beats.

Reset
REQ-029 While rst is high at a clk edge, the block SHALL set: state IDLE; grant 0; rr_ptr NREQ-1, so that requester 0 wins first; timeout counter 0; timeout_err 0.
REQ-030 A reset asserted mid-packet SHALL abandon the packet immediately.
REQ-031 s_tready and fifo_winc SHALL be 0 in the cycle after reset.

Configuration
REQ-032 The feature macro is ARB_TIMEOUT_EN.
REQ-033 With ARB_TIMEOUT_EN defined, a counter SHALL count consecutive XFER cycles where s_tvalid[g]=0, and SHALL clear on any cycle where s_tvalid[g]=1.
REQ-034 With ARB_TIMEOUT_EN defined and the counter reaching TIMEOUT, the block SHALL:
- return to IDLE;
- set rr_ptr to g;
- pulse timeout_err for one cycle;
- write no beat and no tlast.
REQ-035 Cycles stalled by fifo_wfull while s_tvalid[g]=1 SHALL NOT count toward the timeout.
REQ-036 Without ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and the grant SHALL be held indefinitely.

Verification
REQ-037 Reset, then requesters 0 and 2 both send 3-beat packets -> requester 0 is granted first, then requester 2 after one idle cycle; FIFO holds 6 beats in order, fifo_wlast high on beats 3 and 6.
REQ-038 All four requesters hold tvalid continuously with 1-beat packets -> grant sequence 0,1,2,3,0, and fifo_winc high every second cycle.
REQ-039 fifo_wfull held high for 5 cycles mid-packet -> s_tready[g]=0 and fifo_winc=0 for those cycles; grant unchanged; no beat lost or duplicated.
REQ-040 rst pulsed on beat 2 of a 4-beat packet -> grant=0 on the next cycle; the next arbitration picks requester 0.
REQ-041 With ARB_TIMEOUT_EN and TIMEOUT=8, the granted requester drops tvalid for 8 cycles mid-packet -> timeout_err pulses once, state returns to IDLE, and the next requester is granted.
REQ-042 Without ARB_TIMEOUT_EN, the same stall for 100 cycles -> grant held, timeout_err stays 0, and the packet completes when tvalid resumes.

Source files
------------

// File: rtl/axis_fifo_arb.sv
// axis_fifo_arb: round-robin arbiter that gives one AXI-stream requester at a time the FIFO write port.
// Defining ARB_TIMEOUT_EN adds a forced grant release after TIMEOUT idle cycles mid-packet.
module axis_fifo_arb #(
    parameter int NREQ    = 4,
    parameter int DSIZE   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*DSIZE-1:0] s_tdata,
    input  logic [NREQ-1:0]       s_tvalid,
    input  logic [NREQ-1:0]       s_tlast,
    output logic [NREQ-1:0]       s_tready,
    output logic [DSIZE-1:0]      fifo_wdata,
    output logic                  fifo_wlast,
    output logic                  fifo_winc,
    input  logic                  fifo_wfull,
    output logic [NREQ-1:0]       grant,
    output logic                  timeout_err
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic {IDLE, XFER} state_t;
    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_next;
    logic            w_winc;
    // Scan offsets downward so the nearest valid requester after rr_ptr is written last and wins.
    always_comb begin
        w_next = r_rr_ptr;
        for (int k = NREQ; k >= 1; k--)
            if (s_tvalid[(int'(r_rr_ptr) + k) % NREQ]) w_next = IW'((int'(r_rr_ptr) + k) % NREQ);
    end
    assign w_winc     = (r_state == XFER) & s_tvalid[r_gidx] & ~fifo_wfull;
    assign fifo_winc  = w_winc;
    assign fifo_wdata = s_tdata[r_gidx*DSIZE +: DSIZE];
    assign fifo_wlast = w_winc & s_tlast[r_gidx];
    assign grant      = r_grant;
    assign s_tready   = fifo_wfull ? '0 : r_grant;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] r_cnt;
    logic          r_terr;
    assign timeout_err = r_terr;
`else
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = 16'(TIMEOUT);
    assign timeout_err      = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= IW'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_terr   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_terr <= 1'b0;
`endif
            if (r_state == IDLE) begin
                if (|s_tvalid) begin
                    r_state <= XFER;
                    r_gidx  <= w_next;
                    r_grant <= NREQ'(1) << w_next;
                end
`ifdef ARB_TIMEOUT_EN
                r_cnt <= '0;
`endif
            end else if (w_winc && s_tlast[r_gidx]) begin
                r_state  <= IDLE;
                r_grant  <= '0;
                r_rr_ptr <= r_gidx;
            end
`ifdef ARB_TIMEOUT_EN
            else if (s_tvalid[r_gidx]) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                r_state  <= IDLE;
                r_grant  <= '0;
                r_rr_ptr <= r_gidx;
                r_terr   <= 1'b1;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
`endif
        end
    end
endmodule
